// File: rtl/tdes_pkg.sv
// Shared types and constants for the time-multiplexed Triple-DES sequencer.
// Optional three-key mode is enabled with `define TDES_KEY3_EN.
package tdes_pkg;

  localparam int DW_DEF = 64;
  localparam int KW_DEF = 56;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;

  localparam logic MODE_ENC = 1'b1;
  localparam logic MODE_DEC = 1'b0;

endpackage

// File: rtl/tdes_key_sel.sv
// Per-pass key and direction selection for EDE (encrypt) / DED (decrypt).
// With TDES_KEY3_EN undefined the third key is key1 (two-key 3DES).
module tdes_key_sel
  import tdes_pkg::*;
#(
  parameter int KW = KW_DEF
) (
  input  logic [1:0]    pass,
  input  logic          mode,
  input  logic [KW-1:0] key1,
  input  logic [KW-1:0] key2,
`ifdef TDES_KEY3_EN
  input  logic [KW-1:0] key3,
`endif
  output logic [KW-1:0] des_k,
  output logic          des_e
);

  logic [KW-1:0] k3;

`ifdef TDES_KEY3_EN
  assign k3 = key3;
`else
  assign k3 = key1;
`endif

  // Decrypt walks the key schedule backwards, so the outer keys swap ends.
  always_comb begin
    des_k = key1;
    des_e = mode;
    case (pass)
      P0: begin
        des_k = (mode == MODE_ENC) ? key1 : k3;
        des_e = mode;
      end
      P1: begin
        des_k = key2;
        des_e = ~mode;
      end
      default: begin
        des_k = (mode == MODE_ENC) ? k3 : key1;
        des_e = (mode == MODE_DEC) ? MODE_DEC : MODE_ENC;
      end
    endcase
  end

endmodule

// File: rtl/tdes_sequencer.sv
// Drives one shared DES core through the three Triple-DES passes of a block.
// Define TDES_KEY3_EN to add the key3 port (three-key mode).
module tdes_sequencer
  import tdes_pkg::*;
#(
  parameter int DES_LAT = 0,
  parameter int DW      = DW_DEF,
  parameter int KW      = KW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] intext,
  input  logic          e_i,
  input  logic [KW-1:0] key1,
  input  logic [KW-1:0] key2,
`ifdef TDES_KEY3_EN
  input  logic [KW-1:0] key3,
`endif
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] password,
  output logic          busy,
  output logic [DW-1:0] des_in,
  output logic          des_e,
  output logic [KW-1:0] des_k,
  input  logic [DW-1:0] des_out
);

  localparam int CW = (DES_LAT > 0) ? $clog2(DES_LAT + 1) : 1;

  state_t        state, state_n;
  logic [1:0]    pass, pass_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] work, work_n, password_n;
  logic          mode, mode_n;
  logic [KW-1:0] k1, k1_n, k2, k2_n;
`ifdef TDES_KEY3_EN
  logic [KW-1:0] k3, k3_n;
`endif
  logic          accept, last, sel_e;
  logic [KW-1:0] sel_k;

  assign in_ready  = ~abort & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign last      = (cnt == CW'(DES_LAT));
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign des_in    = work;
  assign des_k     = (state == RUN) ? sel_k : k1;
  assign des_e     = (state == RUN) & sel_e;

  tdes_key_sel #(.KW(KW)) u_key_sel (
    .pass  (pass),
    .mode  (mode),
    .key1  (k1),
    .key2  (k2),
`ifdef TDES_KEY3_EN
    .key3  (k3),
`endif
    .des_k (sel_k),
    .des_e (sel_e)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pass     <= P0;
      cnt      <= '0;
      work     <= '0;
      password <= '0;
      mode     <= MODE_DEC;
      k1       <= '0;
      k2       <= '0;
`ifdef TDES_KEY3_EN
      k3       <= '0;
`endif
    end else begin
      state    <= state_n;
      pass     <= pass_n;
      cnt      <= cnt_n;
      work     <= work_n;
      password <= password_n;
      mode     <= mode_n;
      k1       <= k1_n;
      k2       <= k2_n;
`ifdef TDES_KEY3_EN
      k3       <= k3_n;
`endif
    end
  end

  // accept already excludes abort through in_ready, so abort wins over a new block.
  always_comb begin
    state_n    = state;
    pass_n     = pass;
    cnt_n      = cnt;
    work_n     = work;
    password_n = password;
    mode_n     = mode;
    k1_n       = k1;
    k2_n       = k2;
`ifdef TDES_KEY3_EN
    k3_n       = k3;
`endif
    if (abort) begin
      state_n = IDLE;
      pass_n  = P0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: ;
        RUN: begin
          if (last) begin
            work_n = des_out;
            cnt_n  = '0;
            if (pass == P2) begin
              state_n    = DONE;
              password_n = des_out;
              pass_n     = P0;
            end else begin
              pass_n = pass + 2'd1;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        DONE: if (out_ready) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
    if (accept) begin
      state_n = RUN;
      pass_n  = P0;
      cnt_n   = '0;
      work_n  = intext;
      mode_n  = e_i;
      k1_n    = key1;
      k2_n    = key2;
`ifdef TDES_KEY3_EN
      k3_n    = key3;
`endif
    end
  end

endmodule

// File: tb/tb_tdes_sequencer.sv
// Scoreboard bench for tdes_sequencer with a 2-cycle pipelined toy reversible core.
// Expected results come from an EDE/DED composition of the toy cipher.
module tb_tdes_sequencer;

  localparam int LAT     = 2;
  localparam int LATENCY = 3 * (LAT + 1);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, e_i, abort, out_valid, out_ready, busy, des_e;
  logic [63:0] intext, password, des_in, des_out;
  logic [55:0] key1, key2, des_k;
  logic [63:0] stage1, stage2;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        monItem;
  int          tests = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        prevOv = 1'b0;
  logic [63:0] curExp = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tdes_sequencer #(.DES_LAT(LAT), .DW(64), .KW(56)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .intext    (intext),
    .e_i       (e_i),
    .key1      (key1),
    .key2      (key2),
`ifdef TDES_KEY3_EN
    .key3      (key1),
`endif
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .password  (password),
    .busy      (busy),
    .des_in    (des_in),
    .des_e     (des_e),
    .des_k     (des_k),
    .des_out   (des_out)
  );

  function automatic logic [63:0] toyEnc(logic [63:0] x, logic [55:0] k);
    logic [63:0] t;
    t = x ^ {8'h5A, k};
    t = {t[50:0], t[63:51]};
    return t + {k, 8'hC3};
  endfunction

  function automatic logic [63:0] toyDec(logic [63:0] y, logic [55:0] k);
    logic [63:0] t;
    t = y - {k, 8'hC3};
    t = {t[12:0], t[63:13]};
    return t ^ {8'h5A, k};
  endfunction

  function automatic logic [63:0] tdesRef(logic [63:0] p, logic e, logic [55:0] k1, logic [55:0] k2);
    if (e) return toyEnc(toyDec(toyEnc(p, k1), k2), k1);
    return toyDec(toyEnc(toyDec(p, k1), k2), k1);
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Toy core with LAT register stages between operands and result.
  always @(posedge clk) begin
    stage1 <= des_e ? toyEnc(des_in, des_k) : toyDec(des_in, des_k);
    stage2 <= stage1;
  end
  assign des_out = stage2;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop on each rising out_valid, then watch the held result.
  always @(negedge clk) begin
    if (rst_n && out_valid && !prevOv) begin
      if (sbq.size() == 0) begin
        tests++;
        errors++;
        $display("[TB] FAIL unexpected_output: got %h expected none", password);
      end else begin
        monItem = sbq.pop_front();
        curExp  = monItem.data;
        checkOutput("password", password, monItem.data);
        checkOutput("latency", 64'(cyc - monItem.cyc), 64'(LATENCY));
      end
    end else if (rst_n && out_valid && prevOv) begin
      checkOutput("hold", password, curExp);
    end
    prevOv = rst_n && out_valid;
  end

  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic e,
                               input logic [55:0] k1, input logic [55:0] k2,
                               input logic ordy, input logic ab, output logic acc);
    in_valid  = v;
    intext    = d;
    e_i       = e;
    key1      = k1;
    key2      = k2;
    out_ready = ordy;
    abort     = ab;
    #1;
    acc = v && in_ready && rst_n;
    if (acc) sbq.push_back('{tdesRef(d, e, k1, k2), cyc + 1});
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    in_valid  = 1'b0;
    abort     = 1'b0;
    out_ready = ordy;
    repeat (n) @(negedge clk);
  endtask

  task automatic waitOut(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    if (!out_valid) checkOutput("timeout", {63'd0, out_valid}, 64'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    logic        acc;
    logic [63:0] p, c;
    logic [55:0] ka, kb;

    rst_n = 1'b0; in_valid = 0; intext = '0; e_i = 0; key1 = '0; key2 = '0;
    abort = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_password", password, 64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);

    // Encrypt, stall in DONE, then decrypt back-to-back on the release edge.
    ka = 56'(rnd64());
    kb = ka ^ 56'h1;
    p  = rnd64();
    c  = tdesRef(p, 1'b1, ka, kb);
    applyStimulus(1'b1, p, 1'b1, ka, kb, 1'b0, 1'b0, acc);
    checkOutput("accept_idle", {63'd0, acc}, 64'd1);
    idle(0, 1'b0);
    waitOut(LATENCY + 4);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, c, 1'b0, ka, kb, 1'b0, 1'b0, acc);
      checkOutput("stall_no_accept", {63'd0, acc}, 64'd0);
    end
    applyStimulus(1'b1, c, 1'b0, ka, kb, 1'b1, 1'b0, acc);
    checkOutput("same_edge_accept", {63'd0, acc}, 64'd1);
    checkOutput("no_bubble_busy", {63'd0, busy}, 64'd1);
    checkOutput("no_bubble_valid", {63'd0, out_valid}, 64'd0);
    idle(0, 1'b1);
    waitOut(LATENCY + 4);
    checkOutput("roundtrip", password, p);
    idle(2, 1'b1);

    // Abort during pass 1 with a competing block offered.
    applyStimulus(1'b1, rnd64(), 1'b1, 56'(rnd64()), 56'(rnd64()), 1'b1, 1'b0, acc);
    idle(LAT + 1, 1'b1);
    applyStimulus(1'b1, rnd64(), 1'b0, ka, kb, 1'b1, 1'b1, acc);
    checkOutput("abort_in_ready", {63'd0, acc}, 64'd0);
    if (sbq.size() > 0) void'(sbq.pop_back());
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_out_valid", {63'd0, out_valid}, 64'd0);
    idle(LATENCY + 3, 1'b1);
    applyStimulus(1'b1, rnd64(), 1'b0, 56'(rnd64()), 56'(rnd64()), 1'b1, 1'b0, acc);
    idle(0, 1'b1);
    waitOut(LATENCY + 4);
    idle(2, 1'b1);

    // Asynchronous reset in the middle of pass 2.
    applyStimulus(1'b1, rnd64(), 1'b1, 56'(rnd64()), 56'(rnd64()), 1'b1, 1'b0, acc);
    idle(2 * (LAT + 1) + 1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", {63'd0, busy}, 64'd0);
    checkOutput("arst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("arst_password", password, 64'd0);
    if (sbq.size() > 0) void'(sbq.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("arst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);

    // Randomized traffic with random consumer back-pressure.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), rnd64(), 1'($urandom_range(0, 1)),
                    56'(rnd64()), 56'(rnd64()), ($urandom_range(0, 3) != 0), 1'b0, acc);
    end

    idle(4 * LATENCY, 1'b1);
    checkOutput("drain", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
